// File: rtl/coffee_pkg.sv
// Shared definitions for the coin bank controller: coin encodings,
// denomination values and FSM state constants.
package coffee_pkg;

  localparam logic [1:0] CT_50  = 2'b00;
  localparam logic [1:0] CT_100 = 2'b01;
  localparam logic [1:0] CT_500 = 2'b10;
  localparam logic [1:0] CT_INV = 2'b11;

  localparam logic [15:0] DEN_50  = 16'd50;
  localparam logic [15:0] DEN_100 = 16'd100;
  localparam logic [15:0] DEN_500 = 16'd500;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_PAYOUT = 2'd1;
  localparam state_t ST_GAP    = 2'd2;

  // Face value of a coin code; the invalid code maps to 0.
  function automatic logic [15:0] coin_value(input logic [1:0] ct);
    case (ct)
      CT_50:   coin_value = DEN_50;
      CT_100:  coin_value = DEN_100;
      CT_500:  coin_value = DEN_500;
      default: coin_value = 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/payout_selector.sv
// Picks the largest coin that fits in the remaining credit.
// den_oh is {500,100,50}; amt is 0 when the credit is below 50.
module payout_selector
  import coffee_pkg::*;
(
  input  logic [15:0] coin_val,
  output logic [2:0]  den_oh,
  output logic [15:0] amt
);

  // Greedy largest-first denomination choice
  always_comb begin
    den_oh = 3'b000;
    amt    = 16'd0;
    if (coin_val >= DEN_500) begin
      den_oh = 3'b100;
      amt    = DEN_500;
    end else if (coin_val >= DEN_100) begin
      den_oh = 3'b010;
      amt    = DEN_100;
    end else if (coin_val >= DEN_50) begin
      den_oh = 3'b001;
      amt    = DEN_50;
    end
  end

endmodule

// File: rtl/coin_bank_ctrl.sv
// Coin bank controller: accepts coins, charges coffees, pays out change.
// Optional macro COIN_BANK_AUDIT_EN adds a saturating sales_cnt output.
module coin_bank_ctrl
  import coffee_pkg::*;
#(
  parameter int COFFEE_VAL = 300,
  parameter int MAX_VAL    = 9950,
  parameter int DISP_GAP   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coin,
  input  logic [1:0]  coin_type,
  input  logic        coffee_make,
  input  logic        coffee_out,
  input  logic        coin_return,
  output logic [15:0] coin_val,
  output logic        coin_reject,
  output logic        disp_500,
  output logic        disp_100,
  output logic        disp_50,
  output logic        busy,
  output logic        charge_err
`ifdef COIN_BANK_AUDIT_EN
  ,
  output logic [15:0] sales_cnt
`endif
);

  state_t      state;
  logic [3:0]  gap_cnt;
  logic [15:0] cval;
  logic [16:0] sum;
  logic        coin_ok;
  logic        chg_ok;
  logic [15:0] idle_val;
  logic [2:0]  sel_oh;
  logic [15:0] sel_amt;

  payout_selector u_sel (
    .coin_val (coin_val),
    .den_oh   (sel_oh),
    .amt      (sel_amt)
  );

  assign busy = (state != ST_IDLE);

  // Accept/charge decisions; the MAX check uses the pre-charge sum, the
  // charge check uses the credit held before this cycle's coin.
  always_comb begin
    cval     = coin_value(coin_type);
    sum      = {1'b0, coin_val} + {1'b0, cval};
    coin_ok  = coin && (state == ST_IDLE) && (coin_type != CT_INV) &&
               (sum <= 17'(MAX_VAL));
    chg_ok   = coffee_out && coffee_make && (state == ST_IDLE) &&
               (coin_val >= 16'(COFFEE_VAL));
    idle_val = coin_val + (coin_ok ? cval : 16'd0) -
               (chg_ok ? 16'(COFFEE_VAL) : 16'd0);
  end

  // FSM, credit register and one-cycle status pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      coin_val    <= 16'd0;
      gap_cnt     <= 4'd0;
      coin_reject <= 1'b0;
      charge_err  <= 1'b0;
      disp_500    <= 1'b0;
      disp_100    <= 1'b0;
      disp_50     <= 1'b0;
    end else begin
      coin_reject <= coin && !coin_ok;
      charge_err  <= coffee_out && !chg_ok;
      disp_500    <= 1'b0;
      disp_100    <= 1'b0;
      disp_50     <= 1'b0;
      case (state)
        ST_IDLE: begin
          coin_val <= idle_val;
          if (coin_return && (coin_val != 16'd0))
            state <= ST_PAYOUT;
        end
        ST_PAYOUT: begin
          if (sel_amt == 16'd0) begin
            // Sub-50 remainder cannot be paid out; drop it
            coin_val <= 16'd0;
            state    <= ST_IDLE;
          end else begin
            coin_val                     <= coin_val - sel_amt;
            {disp_500, disp_100, disp_50} <= sel_oh;
            gap_cnt                      <= 4'd0;
            state                        <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'(DISP_GAP - 1)) begin
            gap_cnt <= 4'd0;
            state   <= (coin_val != 16'd0) ? ST_PAYOUT : ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef COIN_BANK_AUDIT_EN
  // Successful charges, saturating
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sales_cnt <= 16'd0;
    else if (chg_ok && (sales_cnt != 16'hFFFF))
      sales_cnt <= sales_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_coin_bank_ctrl.sv
// Directed bench for coin_bank_ctrl with hand-computed expectations.
module tb_coin_bank_ctrl;

  localparam logic [1:0] T50 = 2'b00, T100 = 2'b01, T500 = 2'b10, TINV = 2'b11;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        coin = 1'b0;
  logic [1:0]  coin_type = 2'b00;
  logic        coffee_make = 1'b0;
  logic        coffee_out = 1'b0;
  logic        coin_return = 1'b0;
  logic [15:0] coin_val;
  logic        coin_reject, disp_500, disp_100, disp_50, busy, charge_err;
`ifdef COIN_BANK_AUDIT_EN
  logic [15:0] sales_cnt;
`endif

  coin_bank_ctrl #(.COFFEE_VAL(300), .MAX_VAL(9950), .DISP_GAP(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .coin        (coin),
    .coin_type   (coin_type),
    .coffee_make (coffee_make),
    .coffee_out  (coffee_out),
    .coin_return (coin_return),
    .coin_val    (coin_val),
    .coin_reject (coin_reject),
    .disp_500    (disp_500),
    .disp_100    (disp_100),
    .disp_50     (disp_50),
    .busy        (busy),
    .charge_err  (charge_err)
`ifdef COIN_BANK_AUDIT_EN
    ,
    .sales_cnt   (sales_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic insert(input logic [1:0] t);
    coin = 1'b1;
    coin_type = t;
    tick();
    coin = 1'b0;
  endtask

  task automatic brew();
    coffee_out = 1'b1;
    tick();
    coffee_out = 1'b0;
  endtask

  initial begin
    int t500, t100, t50, npulse, multi, busy_low, seen;

    // reset state
    tick(); tick();
    check("rst_val", coin_val, 0);
    check("rst_busy", busy, 0);
    check("rst_pulses", {coin_reject, charge_err, disp_500, disp_100, disp_50}, 0);
    reset = 1'b0;

    // coin_return with empty bank is ignored
    coin_return = 1'b1; tick(); coin_return = 1'b0; tick();
    check("ret_zero_busy", busy, 0);

    // coins 500, 100, 100
    insert(T500); check("c500", coin_val, 500); check("c500_rej", coin_reject, 0);
    insert(T100); check("c600", coin_val, 600);
    insert(T100); check("c700", coin_val, 700); check("c700_rej", coin_reject, 0);

    // charges
    coffee_make = 1'b1;
    brew(); check("chg1", coin_val, 400); check("chg1_err", charge_err, 0);
    brew(); check("chg2", coin_val, 100);
    brew(); check("chg3_err", charge_err, 1); check("chg3_val", coin_val, 100);
    tick(); check("chg_err_pulse", charge_err, 0);
    insert(T500); insert(T50); check("c650", coin_val, 650);
    coffee_make = 1'b0;
    brew(); check("nomake_err", charge_err, 1); check("nomake_val", coin_val, 650);

    // payout of 650 with gap 4
    t500 = -1; t100 = -1; t50 = -1; npulse = 0; multi = 0; busy_low = -1;
    coin_return = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      coin_return = 1'b0;
      if (disp_500) t500 = i;
      if (disp_100) t100 = i;
      if (disp_50) t50 = i;
      npulse += int'(disp_500) + int'(disp_100) + int'(disp_50);
      if ($countones({disp_500, disp_100, disp_50}) > 1) multi++;
      if (!busy && busy_low < 0) busy_low = i;
    end
    check("pay_t500", t500, 2);
    check("pay_t100", t100, 7);
    check("pay_t50", t50, 12);
    check("pay_count", npulse, 3);
    check("pay_onehot", multi, 0);
    check("pay_busy_low", busy_low, 16);
    check("pay_val", coin_val, 0);

    // upper credit limit
    for (int i = 0; i < 19; i++) insert(T500);
    for (int i = 0; i < 4; i++) insert(T100);
    check("c9900", coin_val, 9900);
    insert(T100); check("max_rej", coin_reject, 1); check("max_val", coin_val, 9900);
    insert(T50);  check("edge_acc", coin_reject, 0); check("edge_val", coin_val, 9950);
    insert(TINV); check("inv_rej", coin_reject, 1); check("inv_val", coin_val, 9950);
    insert(T50);  check("full_rej", coin_reject, 1); check("full_val", coin_val, 9950);

    // async reset clears credit mid-cycle
    #2 reset = 1'b1;
    #1 check("areset_val", coin_val, 0);
    tick(); reset = 1'b0;

    // reset during payout of 1000
    insert(T500); insert(T500); check("c1000", coin_val, 1000);
    seen = 0;
    coin_return = 1'b1;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      tick();
      coin_return = 1'b0;
      if (disp_500) seen = 1;
    end
    check("p1_seen", seen, 1);
    check("p1_val", coin_val, 500);
    insert(T50); check("busy_rej", coin_reject, 1); check("busy_rej_val", coin_val, 500);
    coffee_make = 1'b1;
    brew(); check("busy_chg_err", charge_err, 1); check("busy_chg_val", coin_val, 500);
    #2 reset = 1'b1;
    #1 check("mid_rst_val", coin_val, 0); check("mid_rst_busy", busy, 0);
    tick(); reset = 1'b0;
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      npulse += int'(disp_500) + int'(disp_100) + int'(disp_50);
    end
    check("post_rst_pulses", npulse, 0);
    check("post_rst_val", coin_val, 0);

    // same-cycle coin and charge
    insert(T100); insert(T100); insert(T100); check("c300", coin_val, 300);
    coin = 1'b1; coin_type = T500; coffee_out = 1'b1;
    tick();
    coin = 1'b0; coffee_out = 1'b0;
    check("both_val", coin_val, 500);
    check("both_rej", coin_reject, 0);
    check("both_err", charge_err, 0);
`ifdef COIN_BANK_AUDIT_EN
    check("sales_cnt", sales_cnt, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/coin_bank_ctrl.md
COIN_BANK_CTRL -- requirements
Module: coin_bank_ctrl

Interface
REQ-001 Parameter COFFEE_VAL, default 300, price deducted per dispensed coffee.
REQ-002 Parameter MAX_VAL, default 9950, maximum credit held.
REQ-003 Parameter DISP_GAP, default 4, idle cycles after each dispense pulse (range 1..15).
REQ-004 clk  input  1  single clock, all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 coin  input  1  one-cycle pulse, coin inserted.
REQ-007 coin_type  input  2  00=50, 01=100, 10=500, 11=invalid; sampled with coin.
REQ-008 coffee_make  input  1  level, machine is brewing.
REQ-009 coffee_out  input  1  one-cycle pulse, cup delivered.
REQ-010 coin_return  input  1  level, payout requested.
REQ-011 coin_val  output  16  current credit, registered.
REQ-012 coin_reject  output  1  one-cycle pulse, inserted coin refused.
REQ-013 disp_500 / disp_100 / disp_50  output  1 each  one-cycle coin-ejector pulses, mutually exclusive.
REQ-014 busy  output  1  high in PAYOUT and GAP.
REQ-015 charge_err  output  1  one-cycle pulse, coffee_out with insufficient credit.

Function
REQ-016 FSM states: IDLE, PAYOUT, GAP; encoded 2 bits.
REQ-017 IDLE, coin with valid type and coin_val+value <= MAX_VAL: coin_val increases by value on the next edge.
REQ-018 IDLE, coin with coin_type=11 or sum > MAX_VAL: coin_val unchanged, coin_reject high the next cycle.
REQ-019 coin in PAYOUT or GAP: always rejected, coin_reject pulse the next cycle.
REQ-020 coffee_out with coffee_make=1 and coin_val >= COFFEE_VAL: coin_val decreases by COFFEE_VAL the next cycle.
REQ-021 coffee_out with coin_val < COFFEE_VAL, or with coffee_make=0: no deduction, charge_err pulse the next cycle.
REQ-022 Same-cycle valid coin and valid charge in IDLE: both applied, coin_val = old + value - COFFEE_VAL; the MAX_VAL check uses old + value.
REQ-023 IDLE -> PAYOUT when coin_return=1 and coin_val != 0; coin_return with coin_val=0 is ignored.
REQ-024 PAYOUT, one cycle: pulse the largest denomination <= coin_val (500, then 100, then 50), subtract it from coin_val on the same edge, go to GAP.
REQ-025 GAP: counts DISP_GAP cycles, then goes to PAYOUT if coin_val != 0, else IDLE.
REQ-026 Remainder below 50 (unreachable with legal stimulus): cleared to 0 in PAYOUT with no pulse, then IDLE.
REQ-027 Once started, payout runs to zero regardless of coin_return deassertion.
REQ-028 coffee_out during PAYOUT or GAP: no deduction, charge_err pulse.
REQ-029 All arithmetic is 16-bit unsigned; coin_val never wraps or exceeds MAX_VAL.

Reset
REQ-030 reset asserted: state=IDLE, coin_val=0, gap counter=0, all pulse outputs and busy=0, regardless of clock.
REQ-031 Reset mid-payout discards the remaining credit; no further disp_* pulses after release.
REQ-032 First functional edge is the first rising clk edge after reset deasserts.

Configuration
REQ-033 Macro COIN_BANK_AUDIT_EN defined: output sales_cnt[15:0] increments by 1 per successful charge, saturates at 16'hFFFF, and is cleared only by reset.
REQ-034 Macro COIN_BANK_AUDIT_EN undefined: sales_cnt port and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Shared package coffee_pkg holds: coin_type encodings, the denomination constants 50/100/500, and the state type.
REQ-036 Sub-module payout_selector (combinational): given coin_val, returns the denomination one-hot and the subtract amount.

Verification
REQ-037 Reset, then coins 500,100,100 -> coin_val 0 -> 500 -> 600 -> 700, no coin_reject.
REQ-038 coin_val=9900, insert 100 -> coin_reject pulse, coin_val stays 9900; insert coin_type=11 -> coin_reject pulse.
REQ-039 coin_val=700, coffee_make=1, coffee_out -> coin_val 400; second coffee_out -> coin_val 100; third -> charge_err, coin_val stays 100.
REQ-040 coin_val=650, coin_return pulse, DISP_GAP=4 -> disp_500, disp_100, disp_50 each 5 cycles apart, coin_val 0, busy drops, IDLE.
REQ-041 coin_val=1000, reset asserted between the first and second disp_500 -> coin_val 0 immediately, no further pulses.
REQ-042 Same-cycle coin=500 and valid coffee_out at coin_val=300 -> coin_val 500.
